// File: rtl/qdec_lb_multibank.sv
// N-bank occupancy-tracked line buffer for CABAC CTU syntax.
// The writer fills and commits banks in order; the reader consumes and releases them in the same order.
module qdec_lb_multibank #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 12,
    parameter int NUM_BANKS = 2,
    parameter int LVL_W     = $clog2(NUM_BANKS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         wr_en,
    input  logic                         wr_commit,
    output logic                         wr_rdy,
    output logic [$clog2(NUM_BANKS)-1:0] wr_bank,
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_vld,
    output logic [$clog2(NUM_BANKS)-1:0] rd_bank,
    input  logic                         rd_release,
    output logic [LVL_W-1:0]             level,
    input  logic                         err_clr,
    output logic                         err_ovf,
    output logic                         err_udf
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int DEPTH  = 2 ** (BANK_W + ADDR_W);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [BANK_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]  r_count;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_err_ovf, r_err_udf;

    logic w_wr_rdy, w_rd_vld, w_commit_ok, w_rel_ok, w_wr_ok;
    logic [BANK_W-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;

    assign w_wr_rdy    = (r_count < LVL_W'(NUM_BANKS));
    assign w_rd_vld    = (r_count != '0);
    assign w_commit_ok = wr_commit & w_wr_rdy;
    assign w_rel_ok    = rd_release & w_rd_vld;
    assign w_wr_ok     = wr_en & w_wr_rdy;

    // Explicit wrap keeps the ring correct for non-power-of-2 bank counts.
    assign w_wr_ptr_nxt = (r_wr_ptr == BANK_W'(NUM_BANKS - 1)) ? '0 : r_wr_ptr + BANK_W'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == BANK_W'(NUM_BANKS - 1)) ? '0 : r_rd_ptr + BANK_W'(1);

    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_mem[{r_wr_ptr, wr_addr}] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (w_commit_ok)
                r_wr_ptr <= w_wr_ptr_nxt;
            if (w_rel_ok)
                r_rd_ptr <= w_rd_ptr_nxt;
            if (w_commit_ok && !w_rel_ok)
                r_count <= r_count + LVL_W'(1);
            else if (!w_commit_ok && w_rel_ok)
                r_count <= r_count - LVL_W'(1);
            // The memory update happens later in the same step, so this sees the old word.
            if (rd_en)
                r_rd_data <= r_mem[{r_rd_ptr, rd_addr}];
            // A new error in the same cycle as err_clr takes priority.
            if ((wr_en || wr_commit) && !w_wr_rdy)
                r_err_ovf <= 1'b1;
            else if (err_clr)
                r_err_ovf <= 1'b0;
            if (rd_release && !w_rd_vld)
                r_err_udf <= 1'b1;
            else if (err_clr)
                r_err_udf <= 1'b0;
        end
    end

    assign wr_rdy  = w_wr_rdy;
    assign rd_vld  = w_rd_vld;
    assign level   = r_count;
    assign wr_bank = r_wr_ptr;
    assign rd_bank = r_rd_ptr;
    assign rd_data = r_rd_data;
    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;
endmodule

// File: tb/tb_qdec_lb_multibank.sv
// Directed bench for qdec_lb_multibank with three banks and hand-computed expectations.
module tb_qdec_lb_multibank;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 12;
    localparam int NB     = 3;
    localparam int LVL_W  = $clog2(NB + 1);
    localparam int BW     = $clog2(NB);

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic              wr_en, wr_commit, wr_rdy, rd_en, rd_vld, rd_release;
    logic              err_clr, err_ovf, err_udf;
    logic [BW-1:0]     wr_bank, rd_bank;
    logic [LVL_W-1:0]  level;

    int n_vec = 0;
    int n_err = 0;

    qdec_lb_multibank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NB)) dut (
        .clk(clk), .rst(rst),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_commit(wr_commit),
        .wr_rdy(wr_rdy), .wr_bank(wr_bank),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_vld(rd_vld),
        .rd_bank(rd_bank), .rd_release(rd_release),
        .level(level), .err_clr(err_clr), .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs set before the call are sampled at the coming edge; checks follow 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0; err_clr = 0;
    endtask

    task automatic wr(input int a, input int d, input bit commit);
        wr_en = 1; wr_addr = ADDR_W'(a); wr_data = DATA_W'(d); wr_commit = commit;
        tick();
        idle();
    endtask

    task automatic rd(input int a, input bit release_too);
        rd_en = 1; rd_addr = ADDR_W'(a); rd_release = release_too;
        tick();
        idle();
    endtask

    initial begin
        int e;
        idle();
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        rst = 0;
        #1 rst = 1;
        #1;
        chk("rst_level", level, 0);
        chk("rst_wr_rdy", wr_rdy, 1);
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_wr_bank", wr_bank, 0);
        chk("rst_rd_bank", rd_bank, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_errs", {err_ovf, err_udf}, 0);
        tick(); tick();
        rst = 0;

        // bank0 <= 0x10..0x13, then commit
        for (int i = 0; i < 4; i++) wr(i, 'h10 + i, 0);
        chk("pre_commit_rd_vld", rd_vld, 0);
        wr_commit = 1; tick(); idle();
        chk("c1_level", level, 1);
        chk("c1_rd_vld", rd_vld, 1);
        chk("c1_wr_bank", wr_bank, 1);
        rd(2, 0);
        chk("c1_rd_data", rd_data, 'h12);

        // fill remaining banks
        wr(0, 'h21, 1);
        wr(0, 'h31, 1);
        chk("full_level", level, 3);
        chk("full_wr_rdy", wr_rdy, 0);
        chk("full_wr_bank", wr_bank, 0);
        wr(0, 'hEE, 1);
        chk("ovf_flag", err_ovf, 1);
        chk("ovf_level", level, 3);
        chk("ovf_wr_bank", wr_bank, 0);
        rd(0, 0);
        chk("ovf_bank0_kept", rd_data, 'h10);

        // full: commit rejected, release accepted
        wr_commit = 1; rd_release = 1; tick(); idle();
        chk("fullcr_level", level, 2);
        chk("fullcr_rd_bank", rd_bank, 1);
        chk("fullcr_wr_bank", wr_bank, 0);
        chk("fullcr_ovf", err_ovf, 1);
        err_clr = 1; tick(); idle();
        chk("ovf_clr", err_ovf, 0);

        // drain banks 1 and 2, reading the same cycle as release
        rd(0, 1);
        chk("b1_data", rd_data, 'h21);
        chk("b1_rd_bank", rd_bank, 2);
        rd(0, 1);
        chk("b2_data", rd_data, 'h31);
        chk("drain_level", level, 0);
        chk("drain_rd_bank", rd_bank, 0);

        // level=1: commit+release leaves level, moves both pointers
        wr(5, 'h55, 1);
        chk("l1_level", level, 1);
        wr_commit = 1; rd_release = 1; tick(); idle();
        chk("l1cr_level", level, 1);
        chk("l1cr_wr_bank", wr_bank, 2);
        chk("l1cr_rd_bank", rd_bank, 1);
        rd_release = 1; tick(); idle();
        chk("l1_drain", level, 0);

        // wrap: rd=2, wr=2; seven commit/release pairs
        for (int k = 0; k < 7; k++) begin
            e = (2 + k) % NB;
            chk($sformatf("wrap%0d_wr_bank", k), wr_bank, e);
            chk($sformatf("wrap%0d_rd_bank", k), rd_bank, e);
            wr(7, 'h70 + k, 1);
            chk($sformatf("wrap%0d_level", k), level, 1);
            rd(7, 1);
            chk($sformatf("wrap%0d_data", k), rd_data, 'h70 + k);
            chk($sformatf("wrap%0d_rd_next", k), rd_bank, (e + 1) % NB);
        end
        chk("wrap_level", level, 0);

        // underflow, set-wins-over-clear, then clear
        rd_release = 1; tick(); idle();
        chk("udf_flag", err_udf, 1);
        chk("udf_rd_bank", rd_bank, 0);
        rd_release = 1; err_clr = 1; tick(); idle();
        chk("udf_set_wins", err_udf, 1);
        err_clr = 1; tick(); idle();
        chk("udf_clr", err_udf, 0);

        // empty: release rejected, commit accepted
        wr_commit = 1; rd_release = 1; tick(); idle();
        chk("emptycr_level", level, 1);
        chk("emptycr_udf", err_udf, 1);
        chk("emptycr_rd_bank", rd_bank, 0);
        wr_commit = 1; tick(); idle();
        chk("pre_rst_level", level, 2);
        chk("pre_rst_rd_data", rd_data, 'h76);

        // async reset mid-stream, observed before the next edge
        #2 rst = 1;
        #1;
        chk("mrst_level", level, 0);
        chk("mrst_rd_vld", rd_vld, 0);
        chk("mrst_wr_rdy", wr_rdy, 1);
        chk("mrst_rd_data", rd_data, 0);
        chk("mrst_udf", err_udf, 0);
        tick();
        rst = 0;

        // read-before-write on the same physical address, then hold
        wr(9, 'hA1, 0);
        wr_en = 1; wr_addr = 9; wr_data = 'hB2; rd_en = 1; rd_addr = 9;
        tick(); idle();
        chk("rbw_old", rd_data, 'hA1);
        rd(9, 0);
        chk("rbw_new", rd_data, 'hB2);
        rd_addr = 0; tick();
        chk("rd_hold", rd_data, 'hB2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/qdec_lb_multibank.md
Name: qdec_lb_multibank

Overview:
- Parametrised N-bank successor to the CABAC two-bank ping-pong line buffer.
- The CTU syntax writer (ctx FSM) fills one bank per CTU and commits it. Downstream consumers read committed banks and release them explicitly.
- Unlike the blind ping-pong switch, banks are occupancy-tracked. This gives writer backpressure, reader-valid indication and sticky protocol-error flags.

Parameters:
DATA_W, 8, data width of each entry
ADDR_W, 12, per-bank address width; bank depth is 2**ADDR_W
NUM_BANKS, 2, number of banks; legal range 2..8
LVL_W, $clog2(NUM_BANKS+1), width of the occupancy level

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wr_addr  in  ADDR_W  write address within the current write bank
wr_data  in  DATA_W  write data
wr_en  in  1  write strobe
wr_commit  in  1  pulse: current write bank complete (CTU done)
wr_rdy  out  1  a free bank is owned by the writer
wr_bank  out  $clog2(NUM_BANKS)  index of the current write bank
rd_addr  in  ADDR_W  read address within the current read bank
rd_en  in  1  read strobe
rd_data  out  DATA_W  registered read data
rd_vld  out  1  at least one committed bank is available
rd_bank  out  $clog2(NUM_BANKS)  index of the current read bank
rd_release  in  1  pulse: reader finished with the current read bank
level  out  LVL_W  number of committed, unreleased banks
err_clr  in  1  clears the sticky error flags
err_ovf  out  1  sticky: wr_en or wr_commit while wr_rdy=0
err_udf  out  1  sticky: rd_release while rd_vld=0

Behaviour:
- Storage: NUM_BANKS x 2**ADDR_W x DATA_W, single clock, one write port and one read port. Physical address = {bank, addr}.
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, err_ovf=0, err_udf=0. Hence wr_rdy=1, rd_vld=0, level=0, wr_bank=0, rd_bank=0. Memory contents are not reset.
- Reset asserted mid-operation discards all committed banks immediately; nothing partial survives.
- Combinational outputs: wr_rdy = (count < NUM_BANKS); rd_vld = (count != 0); level = count; wr_bank = wr_ptr; rd_bank = rd_ptr.
- Write: when wr_en=1 and wr_rdy=1, mem[wr_ptr][wr_addr] <= wr_data at the clock edge. When wr_en=1 and wr_rdy=0, the write is dropped and err_ovf <= 1.
- Commit: when wr_commit=1 and wr_rdy=1, wr_ptr advances (wraps NUM_BANKS-1 -> 0) and count increments. When wr_rdy=0, the commit is ignored and err_ovf <= 1.
- A wr_en in the same cycle as wr_commit writes to the old wr_ptr bank.
- Read: when rd_en=1, rd_data <= mem[rd_ptr][rd_addr] one cycle later. rd_data holds its value when rd_en=0.
- Reads are performed even when rd_vld=0; the returned data is stale and a don't-care.
- Read and write to the same physical address in the same cycle return the old data (read-before-write).
- Release: when rd_release=1 and rd_vld=1, rd_ptr advances (wraps) and count decrements. When rd_vld=0, the release is ignored and err_udf <= 1.
- A read issued in the same cycle as rd_release uses the old rd_ptr.
- Simultaneous accepted commit and release: both pointers advance and count is unchanged.
- Commit while full plus a release in the same cycle: the commit is still rejected, because wr_rdy is evaluated on the pre-edge count. The release is accepted.
- Release while empty plus a commit in the same cycle: the release is rejected and the commit is accepted.
- Errors are sticky until err_clr=1. If err_clr and a new error condition occur in the same cycle, the flag is set (set wins).
- No bypass path: a committed bank becomes readable in the cycle after the commit edge (rd_vld rises 1 cycle after the commit).
- Pointer and count arithmetic is modulo NUM_BANKS and must be correct for non-power-of-2 NUM_BANKS (e.g. 3).

Test Plan:
- NUM_BANKS=3, reset, write bank0 addr 0..3 = 0x10..0x13, commit:
  - level=1, rd_vld=1, wr_bank=1.
  - rd_addr=2, rd_en -> rd_data=0x12 the next cycle.
- Commit 3 banks with no release -> wr_rdy=0, level=3. A further wr_en and wr_commit -> err_ovf=1, level stays 3, memory of bank0 unchanged.
- Full (level=3), pulse wr_commit and rd_release in the same cycle -> level=2, rd_bank=1, wr_bank unchanged, err_ovf=1.
- level=1, pulse wr_commit and rd_release in the same cycle -> level=1, both pointers advance.
- Wrap check: perform 7 commit/release pairs -> wr_bank and rd_bank cycle 0,1,2,0,...; data in each bank reads back correctly.
- Release at level=0 -> err_udf=1, rd_bank unchanged. err_clr -> err_udf=0.
- Assert rst mid-stream at level=2 -> the same cycle shows level=0, rd_vld=0, wr_rdy=1, rd_data=0.
